// File: rtl/showcase_pipe_if.sv
// showcase_pipe_if: operand/result handshake bundle for showcase_pipe.
//   master : drives a, b, in_vld, out_rdy; observes in_rdy, out_vld, sum, cmp, fitted
//   slave  : the pipe side (mirror of master)
interface showcase_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  in_vld;
  logic                  in_rdy;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH:0]   sum;
  logic [5:0]            cmp;
  logic [FIT_WIDTH-1:0]  fitted;

  modport master (
    output a, b, in_vld, out_rdy,
    input  in_rdy, out_vld, sum, cmp, fitted
  );

  modport slave (
    input  a, b, in_vld, out_rdy,
    output in_rdy, out_vld, sum, cmp, fitted
  );
endinterface

// File: rtl/showcase_pipe.sv
// showcase_pipe: single-slot registered arithmetic stage with a side RAM.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : a (unsigned), b (signed) in; sum = a+b, cmp flags vs CMP_CONST,
//                 fitted = a saturated to FIT_WIDTH bits; valid/ready on both sides
//   i_idx       : RAM index, delayed IDX_DELAY cycles before use (idx_d)
//   o_rd_data   : RAM[idx_d], registered every cycle
//   i_e, i_clr  : sticky flag set / clear (clear wins); o_flag is the flag
//   o_xfer_cnt  : saturating count of accepted input transfers
module showcase_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned IDX_DELAY  = 2,
  parameter int unsigned FIT_WIDTH  = 16,
  parameter int          CMP_CONST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  showcase_pipe_if.slave        bus,
  input  logic [ADDR_WIDTH-1:0] i_idx,
  output logic [7:0]            o_rd_data,
  input  logic                  i_e,
  input  logic                  i_clr,
  output logic                  o_flag,
  output logic [15:0]           o_xfer_cnt
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Same bit pattern, compared unsigned against a and signed against b.
  localparam logic        [DATA_WIDTH-1:0] CmpU = DATA_WIDTH'(CMP_CONST);
  localparam logic signed [DATA_WIDTH-1:0] CmpS = DATA_WIDTH'(CMP_CONST);

  typedef logic [DEPTH-1:0][7:0] ram_t;

  function automatic ram_t ram_init();
    ram_t r;
    for (int n = 0; n < int'(DEPTH); n++) r[n] = 8'(n);
    return r;
  endfunction

  logic                         r_out_vld;
  logic signed [DATA_WIDTH:0]   r_sum;
  logic [5:0]                   r_cmp;
  logic [FIT_WIDTH-1:0]         r_fitted;
  logic [ADDR_WIDTH-1:0]        r_idx_pipe [IDX_DELAY];
  logic [7:0]                   r_rd_data;
  logic                         r_flag;
  logic [15:0]                  r_xfer_cnt;
  // Power-up content only; no reset path touches the array.
  ram_t                         r_ram = ram_init();

  logic                         w_xfer;
  logic signed [DATA_WIDTH:0]   w_sum;
  logic signed [DATA_WIDTH-1:0] w_b_s;
  logic [5:0]                   w_cmp;
  logic [FIT_WIDTH-1:0]         w_fitted;
  logic [ADDR_WIDTH-1:0]        w_idx_d;

  // Ready while in reset so upstream never stalls on a result that reset discards.
  assign bus.in_rdy = !rst_n || !r_out_vld || bus.out_rdy;
  assign w_xfer     = rst_n && bus.in_vld && bus.in_rdy;

  assign w_sum = $signed({1'b0, bus.a}) + $signed({bus.b[DATA_WIDTH-1], bus.b});
  assign w_b_s = $signed(bus.b);

  always_comb begin
    w_cmp    = '0;
    w_cmp[0] = bus.a < CmpU;
    w_cmp[1] = bus.a > CmpU;
    w_cmp[2] = w_b_s <= CmpS;
    w_cmp[3] = w_b_s >= CmpS;
    w_cmp[4] = w_b_s != CmpS;
    w_cmp[5] = w_b_s == CmpS;
  end

  assign w_fitted = (bus.a[DATA_WIDTH-1:FIT_WIDTH] != '0) ? '1 : bus.a[FIT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cmp     <= '0;
      r_fitted  <= '0;
    end else if (w_xfer) begin
      r_out_vld <= 1'b1;
      r_sum     <= w_sum;
      r_cmp     <= w_cmp;
      r_fitted  <= w_fitted;
    end else if (bus.out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign bus.out_vld = r_out_vld;
  assign bus.sum     = r_sum;
  assign bus.cmp     = r_cmp;
  assign bus.fitted  = r_fitted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(IDX_DELAY); i++) r_idx_pipe[i] <= '0;
    end else begin
      r_idx_pipe[0] <= i_idx;
      for (int i = 1; i < int'(IDX_DELAY); i++) r_idx_pipe[i] <= r_idx_pipe[i-1];
    end
  end

  assign w_idx_d = r_idx_pipe[IDX_DELAY-1];

  always_ff @(posedge clk) begin
    if (w_xfer) r_ram[w_idx_d] <= bus.a[7:0];
  end

  // Non-blocking read of the pre-write array gives old data on a same-entry collision.
  always_ff @(posedge clk) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_ram[w_idx_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag     <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_flag <= i_clr ? 1'b0 : (r_flag | i_e);
      if (w_xfer && r_xfer_cnt != 16'hFFFF) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_flag     = r_flag;
  assign o_xfer_cnt = r_xfer_cnt;
endmodule

// File: tb/tb_showcase_pipe.sv
// tb_showcase_pipe: directed plus random stimulus for showcase_pipe, checked every cycle
// against a transaction-level model (result queue, RAM array, index history).
module tb_showcase_pipe;
  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int ID    = 2;
  localparam int FW    = 16;
  localparam int CC    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] idx;
  logic [7:0]    rd_data;
  logic          e;
  logic          clr;
  logic          flag;
  logic [15:0]   xfer_cnt;

  always #5 clk = ~clk;

  showcase_pipe_if #(.DATA_WIDTH(DW), .FIT_WIDTH(FW)) bus ();

  showcase_pipe #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IDX_DELAY (ID),
    .FIT_WIDTH (FW),
    .CMP_CONST (CC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .i_idx     (idx),
    .o_rd_data (rd_data),
    .i_e       (e),
    .i_clr     (clr),
    .o_flag    (flag),
    .o_xfer_cnt(xfer_cnt)
  );

  typedef struct packed {
    logic [DW:0]   sum;
    logic [5:0]    cmp;
    logic [FW-1:0] fit;
  } res_t;

  res_t       exp_q[$];
  int         mem[DEPTH];
  int         hist[$];   // hist[0] newest sampled idx
  logic [7:0] m_rd;
  bit         m_flag;
  int         m_cnt;
  bit         m_zero;    // nothing loaded since reset: result outputs still 0
  int         checks   = 0;
  int         failures = 0;

  function automatic res_t calc(logic [DW-1:0] a, logic [DW-1:0] b);
    longint sa, sb, c, s;
    res_t   r;
    sa    = longint'(a);
    sb    = longint'($signed(b));
    c     = CC;
    s     = sa + sb;
    r.sum = s[DW:0];
    r.cmp = {sb == c, sb != c, sb >= c, sb <= c, sa > c, sa < c};
    r.fit = (sa >= (longint'(1) << FW)) ? {FW{1'b1}} : a[FW-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit exp_rdy, xfer, pop;
    int idx_d;
    @(negedge clk);
    exp_rdy = !rst_n || exp_q.size() == 0 || bus.out_rdy;
    chk("in_rdy", 64'(bus.in_rdy), 64'(exp_rdy));
    chk("out_vld", 64'(bus.out_vld), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("sum", 64'(bus.sum), 64'(exp_q[0].sum));
      chk("cmp", 64'(bus.cmp), 64'(exp_q[0].cmp));
      chk("fitted", 64'(bus.fitted), 64'(exp_q[0].fit));
    end else if (m_zero) begin
      chk("sum_rst", 64'(bus.sum), 64'd0);
      chk("cmp_rst", 64'(bus.cmp), 64'd0);
      chk("fitted_rst", 64'(bus.fitted), 64'd0);
    end
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("flag", 64'(flag), 64'(m_flag));
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));

    xfer  = rst_n && bus.in_vld && exp_rdy;
    pop   = exp_q.size() != 0 && bus.out_rdy;
    idx_d = hist[ID-1];
    if (!rst_n) begin
      exp_q.delete();
      m_rd   = '0;
      m_flag = 1'b0;
      m_cnt  = 0;
      m_zero = 1'b1;
      for (int i = 0; i < ID; i++) hist[i] = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (xfer) begin
        exp_q.push_back(calc(bus.a, bus.b));
        m_zero = 1'b0;
      end
      m_rd = 8'(mem[idx_d]);
      if (xfer) mem[idx_d] = int'(bus.a[7:0]);
      m_flag = clr ? 1'b0 : (m_flag | e);
      if (xfer && m_cnt < 65535) m_cnt++;
      hist.push_front(int'(idx));
      void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.a      = a;
    bus.b      = b;
    bus.in_vld = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    idx         = '0;
    e           = 1'b0;
    clr         = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    for (int n = 0; n < DEPTH; n++) mem[n] = n;
    for (int i = 0; i < ID; i++) hist.push_back(0);
    m_rd   = '0;
    m_flag = 1'b0;
    m_cnt  = 0;
    m_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();  // reset state

    // a=3, b=-5
    send(32'd3, -32'sd5);
    tick();
    chk("r034_sum", 64'(bus.sum), 64'(33'h1_FFFF_FFFE));
    chk("r034_cmp", 64'(bus.cmp), 64'(6'b010101));
    chk("r034_fit", 64'(bus.fitted), 64'd3);
    bus.in_vld = 1'b0;
    tick();

    // fitted saturation boundaries
    send(32'h0001_2345, 32'd0);
    tick();
    chk("r035_fit_big", 64'(bus.fitted), 64'hFFFF);
    send(32'h0000_FFFF, 32'd4);
    tick();
    chk("r035_fit_edge", 64'(bus.fitted), 64'hFFFF);
    send(32'h0000_1234, 32'd5);
    tick();
    chk("r035_fit_pass", 64'(bus.fitted), 64'h1234);
    bus.in_vld = 1'b0;
    tick();

    // backpressure: first result held, second follows once
    bus.out_rdy = 1'b0;
    send(32'd10, 32'd4);
    tick();
    send(32'd20, -32'sd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r036_in_rdy", 64'(bus.in_rdy), 64'd0);
      chk("r036_cnt", 64'(xfer_cnt), 64'd5);
    end
    bus.out_rdy = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    tick();
    tick();

    // idx delay line and RAM read
    idx = 2'd1; tick();
    idx = 2'd2; tick();
    idx = 2'd3; tick();
    chk("r037_rd1", 64'(rd_data), 64'h01);
    tick();
    chk("r037_rd2", 64'(rd_data), 64'h02);
    tick();
    chk("r037_rd3", 64'(rd_data), 64'h03);
    idx = 2'd2;
    tick();
    tick();
    send(32'h0000_00AB, 32'd0);
    tick();
    chk("r037_rdw_old", 64'(rd_data), 64'h02);
    bus.in_vld = 1'b0;
    tick();
    chk("r037_rd_new", 64'(rd_data), 64'hAB);

    // sticky flag
    idx = 2'd0;
    e = 1'b1; tick();
    e = 1'b0; tick();
    chk("r038_set", 64'(flag), 64'd1);
    tick();
    chk("r038_hold", 64'(flag), 64'd1);
    e = 1'b1; clr = 1'b1; tick();
    chk("r038_clr_prio", 64'(flag), 64'd0);
    e = 1'b0; clr = 1'b0; tick();

    // reset with a pending result; in_vld held high during reset
    bus.out_rdy = 1'b0;
    send(32'h0000_0055, 32'd7);
    tick();
    rst_n = 1'b0;
    tick();
    chk("r039_vld", 64'(bus.out_vld), 64'd0);
    chk("r039_sum", 64'(bus.sum), 64'd0);
    chk("r039_cnt", 64'(xfer_cnt), 64'd0);
    rst_n       = 1'b1;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    idx         = 2'd2;
    tick();
    tick();
    tick();
    chk("r039_ram_kept", 64'(rd_data), 64'hAB);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       bus.a = $urandom;
        1:       bus.a = 32'($urandom_range(0, 8));
        2:       bus.a = 32'h0000_FFFE + 32'($urandom_range(0, 3));
        default: bus.a = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
      endcase
      bus.b       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      bus.in_vld  = $urandom_range(0, 3) != 0;
      bus.out_rdy = $urandom_range(0, 3) != 0;
      idx         = AW'($urandom);
      e           = $urandom_range(0, 7) == 0;
      clr         = $urandom_range(0, 7) == 0;
      rst_n       = $urandom_range(0, 63) != 0;
      tick();
    end
    rst_n      = 1'b1;
    bus.in_vld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
